multi_commit_reorder_buffer: RTL and testbench
==============================================

MULTI_COMMIT_REORDER_BUFFER -- requirements
Module: multi_commit_reorder_buffer

Interface
REQ-001 Parameter XLEN, 32, register value width.
REQ-002 Parameter ROB_INDEX_WIDTH, 3, index bits; depth = 2**ROB_INDEX_WIDTH entries.
REQ-003 Parameter EXECUTION_LANES, 2, number of writeback lanes.
REQ-004 Parameter COMMIT_WIDTH, 2, maximum in-order retirements per cycle (1..depth).
REQ-005 Parameter FORWARD_PORTS, 2, number of operand forward ports.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 issue_ROB_valid  in  1  new instruction offered.
REQ-010 issue_ROB_ready  out  1  ROB can accept an instruction.
REQ-011 issue_ROB_dest_reg_index  in  5  destination register.
REQ-012 issue_ROB_index  out  ROB_INDEX_WIDTH  index assigned to the offered instruction (tail).
REQ-013 execute_unit_valids  in  EXECUTION_LANES  per-lane result valid.
REQ-014 execute_unit_indexes  in  EXECUTION_LANES*ROB_INDEX_WIDTH  per-lane target entry.
REQ-015 execute_unit_values  in  EXECUTION_LANES*XLEN  per-lane result.
REQ-016 execute_unit_exceptions  in  EXECUTION_LANES  per-lane result faulted.
REQ-017 forward_request_ROB_valids  in  FORWARD_PORTS  per-port request valid.
REQ-018 forward_request_ROB_indexes  in  FORWARD_PORTS*ROB_INDEX_WIDTH  requested entries.
REQ-019 forward_response_valids  out  FORWARD_PORTS  per-port response valid.
REQ-020 forward_response_values  out  FORWARD_PORTS*XLEN  forwarded values.
REQ-021 commit_valids  out  COMMIT_WIDTH  per-slot retirement valid, slot 0 oldest.
REQ-022 commit_dest_regs  out  COMMIT_WIDTH*5  retired destination registers.
REQ-023 commit_values  out  COMMIT_WIDTH*XLEN  retired values.
REQ-024 exception_valid  out  1  one-cycle pulse: head entry faulted, ROB emptied.
REQ-025 exception_ROB_index  out  ROB_INDEX_WIDTH  index of the faulting entry.
REQ-026 flush  in  1  external flush request.

Function
REQ-027 Entry state is busy, done, exception, dest, value; head/tail pointers carry an extra wrap bit; full when tail-head == depth.
REQ-028 issue_ROB_ready = not full, computed from registered state only; an issue is accepted on an edge with valid&&ready, allocating tail (busy=1, done=0) and advancing tail modulo depth.
REQ-029 A retirement in the same cycle does not raise issue_ROB_ready when full.
REQ-030 A writeback on an edge sets value, done=1 and exception for a busy entry; writebacks to non-busy entries are ignored; if two lanes target the same index, the higher lane wins.
REQ-031 Forward response is registered, one cycle after the request: valid=1 only if the entry was busy and done before that edge, with no bypass of a same-cycle writeback; otherwise valid=0 and value=0.
REQ-032 Commit: on each edge, k = the count of consecutive entries from head that are busy, done and non-faulted, capped at COMMIT_WIDTH.
REQ-033 Those k entries retire; head advances by k; registered commit_valids[k-1:0]=1 with their dest and value for one cycle; other slots read 0.
REQ-034 If the head entry is busy, done and faulted: exception_valid pulses next cycle with its index; all entries are invalidated; head=tail=0; no commit that cycle.
REQ-035 flush has top priority: on that edge all entries are invalidated, head=tail=0, and same-cycle issue, writeback and commit are discarded; outputs are 0 next cycle except issue_ROB_ready=1.
REQ-036 Pointers wrap from depth-1 to 0 with no bubble.

Reset
REQ-037 Reset clears all entries, pointers and registered outputs to 0; issue_ROB_ready=1 and issue_ROB_index=0 while reset is held and after release; reset asserted mid-operation discards all in-flight state.

Structure
REQ-038 Entry field widths and lane/port slicing helpers live in the shared ROB package and are reused by the core.
REQ-039 The leading-done count (k) and the exception detect are one sub-module, rob_commit_select.

Verification (depth 8, 2 lanes, COMMIT_WIDTH 2)
REQ-040 Issue x11..x15 (indexes 0-4); write back idx1-4 = 101-104, then idx0 = 100 -> commits (x11,100),(x12,101); next cycle (x13,102),(x14,103); next (x15,104).
REQ-041 Request idx3 after its writeback -> next-cycle valid=1, value 103; request idx0 before its writeback -> valid=0.
REQ-042 Issue 8 -> ready=0 and a 9th issue is ignored; retire 2, then issue 2 -> indexes 0,1 (wrap).
REQ-043 Issue 3; write back idx0=100, idx1 faulted, idx2=7 -> commit (idx0,100) only; next cycle exception_valid=1 with index 1, ready=1, issue_ROB_index=0.
REQ-044 flush concurrent with an issue and writebacks on both lanes -> nothing allocated or committed; issue_ROB_index=0.
REQ-045 Reset asserted with 4 entries busy -> all outputs 0, ready=1; after release, the next issue receives index 0.

Source files
------------

// File: rtl/multi_commit_reorder_buffer_pkg.sv
// Shared definitions for the multi-commit reorder buffer.
//   REG_INDEX_W : width of an architectural destination register index.
//   rob_flags_t : per-entry status bits (busy, done, exception).
//   lane_lsb    : LSB of element 'lane' inside a flat vector of 'width'-bit elements.
package multi_commit_reorder_buffer_pkg;

    localparam int unsigned REG_INDEX_W = 5;

    typedef struct packed {
        logic busy;
        logic done;
        logic exc;
    } rob_flags_t;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Retirement selection for the reorder buffer.
// Counts the run of consecutive entries starting at the head that are busy, done and
// not faulted, capped at COMMIT_WIDTH, and flags a faulted, completed head entry.
// Ports:
//   head_index_i     : head entry index (no wrap bit)
//   busy_i/done_i/exc_i : per-entry status vectors
//   commit_count_o   : number of entries retiring this cycle
//   head_exception_o : head entry is busy, done and faulted
module rob_commit_select #(
    parameter int unsigned ROB_INDEX_WIDTH = 3,
    parameter int unsigned COMMIT_WIDTH    = 2
) (
    input  logic [ROB_INDEX_WIDTH-1:0]         head_index_i,
    input  logic [(2**ROB_INDEX_WIDTH)-1:0]    busy_i,
    input  logic [(2**ROB_INDEX_WIDTH)-1:0]    done_i,
    input  logic [(2**ROB_INDEX_WIDTH)-1:0]    exc_i,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0]  commit_count_o,
    output logic                               head_exception_o
);

    logic [ROB_INDEX_WIDTH-1:0] idx;
    logic                       stop;

    always_comb begin
        commit_count_o = '0;
        stop           = 1'b0;
        idx            = head_index_i;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            // Index arithmetic is modulo depth, so the run may cross the wrap point.
            idx = head_index_i + ROB_INDEX_WIDTH'(i);
            if (!stop && busy_i[idx] && done_i[idx] && !exc_i[idx]) begin
                commit_count_o = commit_count_o + 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
    end

    assign head_exception_o = busy_i[head_index_i] & done_i[head_index_i] & exc_i[head_index_i];

endmodule

// File: rtl/multi_commit_reorder_buffer.sv
// Multi-commit reorder buffer.
// Allocates entries in program order at the tail, accepts out-of-order writebacks on
// EXECUTION_LANES lanes, serves registered operand forwards, and retires up to
// COMMIT_WIDTH completed entries per cycle from the head. A completed faulted head
// entry raises a one-cycle exception pulse and empties the buffer; flush empties it
// unconditionally.
// Ports:
//   clock, reset                 : rising-edge clock, async active-high reset
//   issue_ROB_*                  : allocation handshake, dest register, assigned index
//   execute_unit_*               : per-lane writeback valid/index/value/exception
//   forward_request_/response_*  : per-port operand forward (one-cycle latency)
//   commit_*                     : per-slot retirement outputs, slot 0 oldest
//   exception_valid/ROB_index    : faulting-head pulse and its index
//   flush                        : external flush request
module multi_commit_reorder_buffer
    import multi_commit_reorder_buffer_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned ROB_INDEX_WIDTH = 3,
    parameter int unsigned EXECUTION_LANES = 2,
    parameter int unsigned COMMIT_WIDTH    = 2,
    parameter int unsigned FORWARD_PORTS   = 2
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        issue_ROB_valid,
    output logic                                        issue_ROB_ready,
    input  logic [4:0]                                  issue_ROB_dest_reg_index,
    output logic [ROB_INDEX_WIDTH-1:0]                  issue_ROB_index,
    input  logic [EXECUTION_LANES-1:0]                  execute_unit_valids,
    input  logic [EXECUTION_LANES*ROB_INDEX_WIDTH-1:0]  execute_unit_indexes,
    input  logic [EXECUTION_LANES*XLEN-1:0]             execute_unit_values,
    input  logic [EXECUTION_LANES-1:0]                  execute_unit_exceptions,
    input  logic [FORWARD_PORTS-1:0]                    forward_request_ROB_valids,
    input  logic [FORWARD_PORTS*ROB_INDEX_WIDTH-1:0]    forward_request_ROB_indexes,
    output logic [FORWARD_PORTS-1:0]                    forward_response_valids,
    output logic [FORWARD_PORTS*XLEN-1:0]               forward_response_values,
    output logic [COMMIT_WIDTH-1:0]                     commit_valids,
    output logic [COMMIT_WIDTH*5-1:0]                   commit_dest_regs,
    output logic [COMMIT_WIDTH*XLEN-1:0]                commit_values,
    output logic                                        exception_valid,
    output logic [ROB_INDEX_WIDTH-1:0]                  exception_ROB_index,
    input  logic                                        flush
);

    localparam int unsigned IW    = ROB_INDEX_WIDTH;
    localparam int unsigned DEPTH = 2**ROB_INDEX_WIDTH;
    localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH+1);

    rob_flags_t             flags_q [DEPTH];
    rob_flags_t             flags_d [DEPTH];
    logic [REG_INDEX_W-1:0] dest_q  [DEPTH];
    logic [REG_INDEX_W-1:0] dest_d  [DEPTH];
    logic [XLEN-1:0]        value_q [DEPTH];
    logic [XLEN-1:0]        value_d [DEPTH];

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [IW:0] head_q, head_d;
    logic [IW:0] tail_q, tail_d;

    logic [FORWARD_PORTS-1:0]             fwd_valid_q, fwd_valid_d;
    logic [FORWARD_PORTS*XLEN-1:0]        fwd_value_q, fwd_value_d;
    logic [COMMIT_WIDTH-1:0]              cmt_valid_q, cmt_valid_d;
    logic [COMMIT_WIDTH*REG_INDEX_W-1:0]  cmt_dest_q, cmt_dest_d;
    logic [COMMIT_WIDTH*XLEN-1:0]         cmt_value_q, cmt_value_d;
    logic                                 exc_valid_q, exc_valid_d;
    logic [IW-1:0]                        exc_index_q, exc_index_d;

    logic             full;
    logic [DEPTH-1:0] busy_vec, done_vec, exc_vec;
    logic [CNT_W-1:0] commit_count;
    logic             head_exception;
    logic [IW-1:0]    fwd_idx, wb_idx, slot_idx;

    assign full            = (tail_q[IW] != head_q[IW]) && (tail_q[IW-1:0] == head_q[IW-1:0]);
    assign issue_ROB_ready = ~full;
    assign issue_ROB_index = tail_q[IW-1:0];

    always_comb begin
        busy_vec = '0;
        done_vec = '0;
        exc_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i] = flags_q[i].busy;
            done_vec[i] = flags_q[i].done;
            exc_vec[i]  = flags_q[i].exc;
        end
    end

    rob_commit_select #(
        .ROB_INDEX_WIDTH (ROB_INDEX_WIDTH),
        .COMMIT_WIDTH    (COMMIT_WIDTH)
    ) u_commit_select (
        .head_index_i     (head_q[IW-1:0]),
        .busy_i           (busy_vec),
        .done_i           (done_vec),
        .exc_i            (exc_vec),
        .commit_count_o   (commit_count),
        .head_exception_o (head_exception)
    );

    always_comb begin
        flags_d     = flags_q;
        dest_d      = dest_q;
        value_d     = value_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fwd_valid_d = '0;
        fwd_value_d = '0;
        cmt_valid_d = '0;
        cmt_dest_d  = '0;
        cmt_value_d = '0;
        exc_valid_d = 1'b0;
        exc_index_d = '0;
        fwd_idx     = '0;
        wb_idx      = '0;
        slot_idx    = '0;

        // Forwards see only pre-edge state: a same-cycle writeback is not bypassed.
        for (int p = 0; p < FORWARD_PORTS; p++) begin
            fwd_idx = forward_request_ROB_indexes[lane_lsb(p, IW) +: IW];
            if (forward_request_ROB_valids[p] && flags_q[fwd_idx].busy
                && flags_q[fwd_idx].done) begin
                fwd_valid_d[p]                       = 1'b1;
                fwd_value_d[lane_lsb(p, XLEN) +: XLEN] = value_q[fwd_idx];
            end
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                flags_d[i] = '0;
            end
            head_d      = '0;
            tail_d      = '0;
            fwd_valid_d = '0;
            fwd_value_d = '0;
        end else if (head_exception) begin
            for (int i = 0; i < DEPTH; i++) begin
                flags_d[i] = '0;
            end
            head_d      = '0;
            tail_d      = '0;
            exc_valid_d = 1'b1;
            exc_index_d = head_q[IW-1:0];
        end else begin
            // Ascending lane order lets the higher lane win on an index collision.
            for (int l = 0; l < EXECUTION_LANES; l++) begin
                wb_idx = execute_unit_indexes[lane_lsb(l, IW) +: IW];
                if (execute_unit_valids[l] && flags_q[wb_idx].busy) begin
                    value_d[wb_idx]      = execute_unit_values[lane_lsb(l, XLEN) +: XLEN];
                    flags_d[wb_idx].done = 1'b1;
                    flags_d[wb_idx].exc  = execute_unit_exceptions[l];
                end
            end

            // Retirement after writeback so a retired entry always ends up fully cleared.
            for (int s = 0; s < COMMIT_WIDTH; s++) begin
                if (CNT_W'(s) < commit_count) begin
                    slot_idx                                   = head_q[IW-1:0] + IW'(s);
                    cmt_valid_d[s]                             = 1'b1;
                    cmt_dest_d[lane_lsb(s, REG_INDEX_W) +: REG_INDEX_W] = dest_q[slot_idx];
                    cmt_value_d[lane_lsb(s, XLEN) +: XLEN]     = value_q[slot_idx];
                    flags_d[slot_idx]                          = '0;
                end
            end
            head_d = head_q + (IW+1)'(commit_count);

            // Readiness comes from registered state: retiring this cycle does not free a slot.
            if (issue_ROB_valid && !full) begin
                flags_d[tail_q[IW-1:0]] = '{busy: 1'b1, done: 1'b0, exc: 1'b0};
                dest_d[tail_q[IW-1:0]]  = issue_ROB_dest_reg_index;
                value_d[tail_q[IW-1:0]] = '0;
                tail_d                  = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                flags_q[i] <= '0;
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            fwd_valid_q <= '0;
            fwd_value_q <= '0;
            cmt_valid_q <= '0;
            cmt_dest_q  <= '0;
            cmt_value_q <= '0;
            exc_valid_q <= 1'b0;
            exc_index_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                flags_q[i] <= flags_d[i];
                dest_q[i]  <= dest_d[i];
                value_q[i] <= value_d[i];
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_value_q <= fwd_value_d;
            cmt_valid_q <= cmt_valid_d;
            cmt_dest_q  <= cmt_dest_d;
            cmt_value_q <= cmt_value_d;
            exc_valid_q <= exc_valid_d;
            exc_index_q <= exc_index_d;
        end
    end

    assign forward_response_valids = fwd_valid_q;
    assign forward_response_values = fwd_value_q;
    assign commit_valids           = cmt_valid_q;
    assign commit_dest_regs        = cmt_dest_q;
    assign commit_values           = cmt_value_q;
    assign exception_valid         = exc_valid_q;
    assign exception_ROB_index     = exc_index_q;

endmodule

// File: tb/tb_multi_commit_reorder_buffer.sv
// Testbench for multi_commit_reorder_buffer (depth 8, 2 lanes, commit width 2, 2 ports).
// Directed scenarios followed by random traffic, all checked against an in-order queue
// model of the buffer.
module tb_multi_commit_reorder_buffer;

    localparam int XLEN  = 32;
    localparam int IW    = 3;
    localparam int LANES = 2;
    localparam int CW    = 2;
    localparam int FP    = 2;
    localparam int DEPTH = 8;

    logic                  clock;
    logic                  reset;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [4:0]            issue_dest;
    logic [IW-1:0]         issue_idx;
    logic [LANES-1:0]      eu_valids;
    logic [LANES*IW-1:0]   eu_idx;
    logic [LANES*XLEN-1:0] eu_vals;
    logic [LANES-1:0]      eu_exc;
    logic [FP-1:0]         fr_valids;
    logic [FP*IW-1:0]      fr_idx;
    logic [FP-1:0]         fw_valids;
    logic [FP*XLEN-1:0]    fw_vals;
    logic [CW-1:0]         c_valids;
    logic [CW*5-1:0]       c_dests;
    logic [CW*XLEN-1:0]    c_vals;
    logic                  ex_valid;
    logic [IW-1:0]         ex_idx;
    logic                  flush;

    multi_commit_reorder_buffer #(
        .XLEN            (XLEN),
        .ROB_INDEX_WIDTH (IW),
        .EXECUTION_LANES (LANES),
        .COMMIT_WIDTH    (CW),
        .FORWARD_PORTS   (FP)
    ) dut (
        .clock                       (clock),
        .reset                       (reset),
        .issue_ROB_valid             (issue_valid),
        .issue_ROB_ready             (issue_ready),
        .issue_ROB_dest_reg_index    (issue_dest),
        .issue_ROB_index             (issue_idx),
        .execute_unit_valids         (eu_valids),
        .execute_unit_indexes        (eu_idx),
        .execute_unit_values         (eu_vals),
        .execute_unit_exceptions     (eu_exc),
        .forward_request_ROB_valids  (fr_valids),
        .forward_request_ROB_indexes (fr_idx),
        .forward_response_valids     (fw_valids),
        .forward_response_values     (fw_vals),
        .commit_valids               (c_valids),
        .commit_dest_regs            (c_dests),
        .commit_values               (c_vals),
        .exception_valid             (ex_valid),
        .exception_ROB_index         (ex_idx),
        .flush                       (flush)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: in-flight instructions in program order, oldest first.
    typedef struct {
        int          idx;
        int          dest;
        bit          done;
        bit          exc;
        logic [31:0] val;
    } ent_t;

    ent_t mq[$];
    int   m_tail;

    logic [CW-1:0]      e_cv;
    logic [CW*5-1:0]    e_cd;
    logic [CW*XLEN-1:0] e_cval;
    logic               e_exv;
    logic [IW-1:0]      e_exi;
    logic [FP-1:0]      e_fv;
    logic [FP*XLEN-1:0] e_fval;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input int idx);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].idx == idx) return i;
        end
        return -1;
    endfunction

    task automatic clear_expect();
        e_cv   = '0;
        e_cd   = '0;
        e_cval = '0;
        e_exv  = 1'b0;
        e_exi  = '0;
        e_fv   = '0;
        e_fval = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_tail = 0;
        clear_expect();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_update();
        bit   acc;
        int   pos;
        int   k;
        ent_t t;
        clear_expect();
        acc = issue_valid && (mq.size() < DEPTH);
        if (flush) begin
            mq.delete();
            m_tail = 0;
            return;
        end
        for (int p = 0; p < FP; p++) begin
            if (fr_valids[p]) begin
                pos = find(int'(fr_idx[p*IW +: IW]));
                if (pos >= 0 && mq[pos].done) begin
                    e_fv[p]               = 1'b1;
                    e_fval[p*XLEN +: XLEN] = mq[pos].val;
                end
            end
        end
        if (mq.size() > 0 && mq[0].done && mq[0].exc) begin
            e_exv = 1'b1;
            e_exi = 3'(mq[0].idx);
            mq.delete();
            m_tail = 0;
            return;
        end
        k = 0;
        while (k < CW && k < mq.size() && mq[k].done && !mq[k].exc) begin
            e_cv[k]                = 1'b1;
            e_cd[k*5 +: 5]         = 5'(mq[k].dest);
            e_cval[k*XLEN +: XLEN] = mq[k].val;
            k++;
        end
        repeat (k) void'(mq.pop_front());
        for (int l = 0; l < LANES; l++) begin
            if (eu_valids[l]) begin
                pos = find(int'(eu_idx[l*IW +: IW]));
                if (pos >= 0) begin
                    t      = mq[pos];
                    t.done = 1'b1;
                    t.exc  = eu_exc[l];
                    t.val  = eu_vals[l*XLEN +: XLEN];
                    mq[pos] = t;
                end
            end
        end
        if (acc) begin
            t.idx  = m_tail;
            t.dest = int'(issue_dest);
            t.done = 1'b0;
            t.exc  = 1'b0;
            t.val  = '0;
            mq.push_back(t);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic check_all();
        chk("ready", 64'(issue_ready), 64'(mq.size() < DEPTH));
        chk("issue_index", 64'(issue_idx), 64'(m_tail));
        chk("commit_valids", 64'(c_valids), 64'(e_cv));
        chk("commit_dests", 64'(c_dests), 64'(e_cd));
        chk("commit_values", 64'(c_vals), 64'(e_cval));
        chk("exception_valid", 64'(ex_valid), 64'(e_exv));
        chk("exception_index", 64'(ex_idx), 64'(e_exi));
        chk("fwd_valids", 64'(fw_valids), 64'(e_fv));
        chk("fwd_values", 64'(fw_vals), 64'(e_fval));
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_dest  = '0;
        eu_valids   = '0;
        eu_idx      = '0;
        eu_vals     = '0;
        eu_exc      = '0;
        fr_valids   = '0;
        fr_idx      = '0;
        flush       = 1'b0;
    endtask

    task automatic set_wb(input int lane, input int idx, input int val, input bit exc);
        eu_valids[lane]            = 1'b1;
        eu_idx[lane*IW +: IW]      = 3'(idx);
        eu_vals[lane*XLEN +: XLEN] = 32'(val);
        eu_exc[lane]               = exc;
    endtask

    task automatic set_fwd(input int port, input int idx);
        fr_valids[port]       = 1'b1;
        fr_idx[port*IW +: IW] = 3'(idx);
    endtask

    task automatic issue(input int dest);
        issue_valid = 1'b1;
        issue_dest  = 5'(dest);
    endtask

    // Asserts reset away from a clock edge, checks while held, releases it.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        #3;
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Out-of-order completion, in-order double-wide retirement, forwarding.
        for (int i = 0; i < 5; i++) begin
            idle();
            issue(11 + i);
            chk("r40_issue_index", 64'(issue_idx), 64'(i));
            step();
        end
        idle(); set_wb(0, 1, 101, 0); set_wb(1, 2, 102, 0); step();
        idle(); set_wb(0, 3, 103, 0); set_wb(1, 4, 104, 0); step();
        idle(); set_wb(0, 0, 100, 0); set_fwd(0, 3); set_fwd(1, 0); step();
        chk("r41_fwd_valids", 64'(fw_valids), 64'h1);
        chk("r41_fwd_value0", 64'(fw_vals[31:0]), 64'd103);
        chk("r41_fwd_value1", 64'(fw_vals[63:32]), 64'd0);
        chk("r40_no_early_commit", 64'(c_valids), 64'h0);
        idle(); step();
        chk("r40_c1_valids", 64'(c_valids), 64'h3);
        chk("r40_c1_dests", 64'(c_dests), {54'd0, 5'd12, 5'd11});
        chk("r40_c1_values", 64'(c_vals), {32'd101, 32'd100});
        idle(); step();
        chk("r40_c2_dests", 64'(c_dests), {54'd0, 5'd14, 5'd13});
        chk("r40_c2_values", 64'(c_vals), {32'd103, 32'd102});
        idle(); step();
        chk("r40_c3_valids", 64'(c_valids), 64'h1);
        chk("r40_c3_dest", 64'(c_dests), 64'd15);
        chk("r40_c3_value", 64'(c_vals), 64'd104);
        idle(); step();
        chk("r40_drained", 64'(c_valids), 64'h0);

        // Fill, overflow attempt, retire two, wrap-around allocation.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); issue(1 + i); step();
        end
        chk("r42_full_ready", 64'(issue_ready), 64'h0);
        idle(); issue(20); step();
        chk("r42_ninth_ignored", 64'(issue_idx), 64'h0);
        idle(); issue(21); set_wb(0, 0, 5, 0); set_wb(1, 1, 6, 0); step();
        chk("r42_still_full", 64'(issue_ready), 64'h0);
        idle(); issue(21); step();
        chk("r42_retire_two", 64'(c_valids), 64'h3);
        chk("r42_ready_after", 64'(issue_ready), 64'h1);
        chk("r42_wrap_index0", 64'(issue_idx), 64'h0);
        idle(); issue(22); step();
        chk("r42_wrap_index1", 64'(issue_idx), 64'h1);
        idle(); issue(23); step();
        chk("r42_full_again", 64'(issue_ready), 64'h0);

        // Faulting entry behind a good one.
        idle(); flush = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            idle(); issue(1 + i); step();
        end
        idle(); set_wb(0, 0, 100, 0); set_wb(1, 1, 55, 1); step();
        idle(); set_wb(0, 2, 7, 0); step();
        chk("r43_commit_valids", 64'(c_valids), 64'h1);
        chk("r43_commit_value", 64'(c_vals), 64'd100);
        chk("r43_no_exc_yet", 64'(ex_valid), 64'h0);
        idle(); step();
        chk("r43_exc_valid", 64'(ex_valid), 64'h1);
        chk("r43_exc_index", 64'(ex_idx), 64'h1);
        chk("r43_ready", 64'(issue_ready), 64'h1);
        chk("r43_issue_index", 64'(issue_idx), 64'h0);
        chk("r43_no_commit", 64'(c_valids), 64'h0);
        idle(); step();
        chk("r43_exc_pulse", 64'(ex_valid), 64'h0);

        // Flush concurrent with issue and both writeback lanes.
        idle(); issue(4); step();
        idle(); issue(5); set_wb(0, 0, 9, 0); step();
        idle(); flush = 1'b1; issue(6); set_wb(0, 1, 10, 0); set_wb(1, 0, 11, 0); step();
        chk("r44_issue_index", 64'(issue_idx), 64'h0);
        chk("r44_no_commit", 64'(c_valids), 64'h0);
        chk("r44_ready", 64'(issue_ready), 64'h1);
        idle(); step();
        chk("r44_nothing_left", 64'(c_valids), 64'h0);

        // Reset in the middle of operation.
        for (int i = 0; i < 4; i++) begin
            idle(); issue(8 + i); step();
        end
        idle();
        do_reset();
        chk("r45_ready", 64'(issue_ready), 64'h1);
        chk("r45_index", 64'(issue_idx), 64'h0);
        idle(); issue(30); step();
        chk("r45_next_index", 64'(issue_idx), 64'h1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_dest  = 5'($urandom);
            eu_valids   = 2'($urandom);
            eu_idx      = 6'($urandom);
            eu_vals     = {$urandom, $urandom};
            eu_exc[0]   = ($urandom_range(0, 15) == 0);
            eu_exc[1]   = ($urandom_range(0, 15) == 0);
            fr_valids   = 2'($urandom);
            fr_idx      = 6'($urandom);
            flush       = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
